divv: RTL and testbench
=======================

# divv

Sequential unsigned restoring divider: the inverse of the triangle datapath's multiply-accumulate stage. Takes a 20-bit accumulated value and a 10-bit divisor, then produces quotient and remainder one bit per clock. Sits after the accumulator, for example to normalise an area sum by a count, and uses a start/busy/done handshake.

## Interface
- `N`, default 20: dividend and quotient width.
- `M`, default 10: divisor and remainder width. Requires M < N.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `start` in 1: request a division. Sampled only in IDLE or DONE.
- `dividend` in N: numerator, captured when start is accepted.
- `divisor` in M: denominator, captured when start is accepted.
- `busy` out 1: high while in RUN.
- `done` out 1: single-cycle pulse when results become valid.
- `quotient` out N: result, held until the next accepted start.
- `remainder` out M: result, held until the next accepted start.
- `div_by_zero` out 1: set with `done` when the captured divisor was 0. Held with the results.

## Operation
- FSM states: IDLE, RUN, DONE.
- Internal registers:
  - `rem`: M+1 bits.
  - `q`: N bits, shift register that also holds the remaining dividend bits.
  - `d`: M bits.
  - `cnt`: ceil(log2(N+1)) bits.
- IDLE or DONE with `start`=1:
  - Capture `q`<=dividend, `d`<=divisor, `rem`<=0, `cnt`<=N.
  - Go to RUN. `quotient`/`remainder`/`div_by_zero` stay at the old values until the new `done`.
- RUN, each cycle:
  - `t` = {rem[M-1:0], q[N-1]}.
  - If `t` >= {1'b0,d}: `rem`<=t-d, `q`<={q[N-2:0],1}. Otherwise: `rem`<=t, `q`<={q[N-2:0],0}.
  - `cnt`<=cnt-1. When `cnt`==1, the next state is DONE.
- RUN→DONE transition:
  - `quotient`<=final q, `remainder`<=final rem[M-1:0].
  - `done`=1 for exactly the DONE cycle.
- DONE without `start`: go to IDLE. DONE with `start`: accept it (back-to-back operation).
- `start` during RUN is ignored; no queueing.
- Dividend and divisor inputs are don't-care except at the accepting edge.
- Arithmetic is unsigned only. Results satisfy dividend = quotient*divisor + remainder, remainder < divisor.
- Divide by zero yields quotient = all ones and remainder = dividend[M-1:0]. See Configuration for latency and flag.
- Reset values: every output is 0, state is IDLE, internal registers are 0.
- Reset mid-RUN aborts the division; no `done` is produced.

## Timing
- `start` accepted at edge k: `busy`=1 from k+1 through k+N.
- `done`=1 in the cycle after edge k+N (the DONE state). Results are valid from that cycle.
- Latency is N+1 cycles from the accepting edge to `done`. Throughput is one division per N+1 cycles with back-to-back `start` in DONE.
- `busy` and `done` are never high together.
- `reset` has priority over `start` in the same cycle.

## Configuration
- Macro: `DIVV_ZERO_CHECK_EN`.
- Defined:
  - A zero divisor at accept goes directly to DONE at the next edge; `done` arrives 2 cycles after the `start` edge and `busy` stays 0.
  - Outputs: quotient = all ones, remainder = dividend[M-1:0], `div_by_zero`=1.
  - `div_by_zero` clears at the next accepted start.
- Not defined:
  - `div_by_zero` is tied to 0.
  - A zero divisor runs the full N-cycle RUN. The restoring loop naturally yields the same quotient and remainder values with normal latency.

## Test plan
- 1000/7 with start pulse:
  - `done` exactly N+1 cycles later.
  - quotient=142, remainder=6, `div_by_zero`=0.
  - `busy` high for 20 cycles.
- 1048575/1023:
  - quotient=1025, remainder=0.
  - Then 5/10 issued back-to-back in the DONE cycle gives quotient=0, remainder=5.
- 0x12345/0:
  - quotient=0xFFFFF, remainder=0x345.
  - With macro: `done` 2 cycles after start, `div_by_zero`=1.
  - Without macro: `done` at N+1, flag 0.
- Start 1000/7, then pulse `start` with 50/3 at cycle 5 of RUN:
  - Second start is ignored; result is 142 r 6.
  - Exactly one `done`.
- Start 1000/7, assert `reset` at RUN cycle 10:
  - All outputs 0, IDLE next cycle, no `done`.
  - A subsequent 100/9 gives quotient 11, remainder 1.
- Random regression, 1000 operand pairs with divisor≠0:
  - quotient*divisor+remainder == dividend.
  - remainder < divisor.

Source files
------------

// File: rtl/divv.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVV_ZERO_CHECK_EN to short-cut zero divisors and raise div_by_zero; otherwise the flag stays 0.
module divv #(
  parameter int unsigned N = 20,
  parameter int unsigned M = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

`ifdef DIVV_ZERO_CHECK_EN
  localparam bit ZERO_CHECK = 1'b1;
`else
  localparam bit ZERO_CHECK = 1'b0;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_next;
  logic [M:0]    rem, rem_next, t;
  logic [N-1:0]  q, q_next, quotient_next;
  logic [M-1:0]  d, d_next, remainder_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          busy_next, done_next, dbz_next;

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_next     = state;
    rem_next       = rem;
    q_next         = q;
    d_next         = d;
    cnt_next       = cnt;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    t              = {rem[M-1:0], q[N-1]};

    case (state)
      IDLE, DONE: begin
        if (start) begin
          q_next     = dividend;
          d_next     = divisor;
          rem_next   = '0;
          cnt_next   = CW'(N);
          state_next = RUN;
          busy_next  = !(ZERO_CHECK && divisor == '0);
          dbz_next   = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (ZERO_CHECK && d == '0) begin
          // Zero divisor skips the loop; results match what the loop would produce
          state_next     = DONE;
          done_next      = 1'b1;
          quotient_next  = '1;
          remainder_next = q[M-1:0];
          dbz_next       = 1'b1;
        end else begin
          if (rem[M] || t >= {1'b0, d}) begin
            rem_next = t - {1'b0, d};
            q_next   = {q[N-2:0], 1'b1};
          end else begin
            rem_next = t;
            q_next   = {q[N-2:0], 1'b0};
          end
          cnt_next = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_next     = DONE;
            done_next      = 1'b1;
            quotient_next  = q_next;
            remainder_next = rem_next[M-1:0];
          end else begin
            busy_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      rem         <= rem_next;
      q           <= q_next;
      d           <= d_next;
      cnt         <= cnt_next;
      busy        <= busy_next;
      done        <= done_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
    end
  end

endmodule

// File: tb/tb_divv.sv
// Self-checking bench for divv: directed cases plus a random regression against an arithmetic model.
module tb_divv;

  localparam int unsigned N = 20;
  localparam int unsigned M = 10;

`ifdef DIVV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  divv #(.N(N), .M(M)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request; the next rising edge is the accepting edge
  task automatic launch(input logic [N-1:0] dvd, input logic [M-1:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
  endtask

  // Wait for done, checking latency, busy width and results against plain arithmetic
  task automatic wait_done(input string tag, input logic [N-1:0] dvd, input logic [M-1:0] dvs,
                           input int poke_at);
    int cycles = 0;
    int busy_cnt = 0;
    int overlap = 0;
    logic [N-1:0] exp_q;
    logic [M-1:0] exp_r;
    int exp_lat, exp_busy;
    bit zero;
    zero     = (dvs == '0);
    exp_q    = zero ? '1 : N'(dvd / dvs);
    exp_r    = zero ? dvd[M-1:0] : M'(dvd % dvs);
    exp_lat  = (ZC && zero) ? 2 : N + 1;
    exp_busy = (ZC && zero) ? 0 : N;
    forever begin
      tick();
      start = 1'b0;
      cycles++;
      if (cycles == poke_at) launch(20'd50, 10'd3);
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) break;
      if (cycles >= 100) begin
        check({tag, " timeout"}, 32'd0, 32'd1);
        start = 1'b0;
        return;
      end
    end
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ZC && zero));
  endtask

  initial begin
    int dones;
    logic [N-1:0] rd;
    logic [M-1:0] rv;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    tick();

    // 1000/7 with a one-cycle start pulse
    launch(20'd1000, 10'd7);
    wait_done("d1000_7", 20'd1000, 10'd7, -1);
    check("d1000_7 q142", 32'(quotient), 32'd142);
    check("d1000_7 r6", 32'(remainder), 32'd6);
    tick(); tick();

    // Max dividend, then back-to-back start issued in the DONE cycle
    launch(20'd1048575, 10'd1023);
    wait_done("dmax", 20'd1048575, 10'd1023, -1);
    check("dmax q1025", 32'(quotient), 32'd1025);
    launch(20'd5, 10'd10);
    wait_done("b2b_5_10", 20'd5, 10'd10, -1);
    check("b2b q0", 32'(quotient), 32'd0);
    check("b2b r5", 32'(remainder), 32'd5);
    tick();

    // Divide by zero
    launch(20'h12345, 10'd0);
    wait_done("dzero", 20'h12345, 10'd0, -1);
    check("dzero q", 32'(quotient), 32'hFFFFF);
    check("dzero r", 32'(remainder), 32'h345);
    tick();

    // Start during RUN must be ignored; results held and done single-cycle
    launch(20'd1000, 10'd7);
    wait_done("ignore", 20'd1000, 10'd7, 5);
    tick();
    check("ignore done_pulse", 32'(done), 32'd0);
    check("ignore hold_q", 32'(quotient), 32'd142);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dones++;
    end
    check("ignore extra_done", 32'(dones), 32'd0);

    // Reset mid-RUN aborts
    launch(20'd1000, 10'd7);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort dbz", 32'(div_by_zero), 32'd0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    launch(20'd100, 10'd9);
    wait_done("after_abort", 20'd100, 10'd9, -1);
    check("after_abort q11", 32'(quotient), 32'd11);
    check("after_abort r1", 32'(remainder), 32'd1);

    // Random regression, mixing idle gaps with back-to-back issue
    for (int i = 0; i < 1000; i++) begin
      rd = N'($urandom);
      rv = M'($urandom_range(1, (1 << M) - 1));
      if ($urandom_range(0, 3) == 0) tick();
      launch(rd, rv);
      wait_done("rand", rd, rv, -1);
      check("rand identity", 32'(quotient) * 32'(rv) + 32'(remainder), 32'(rd));
      check("rand rem_lt_div", 32'(remainder < rv), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
